kerygma_bus_arb: RTL and testbench



---
 rtl/kerygma_bus_arb.sv | 200 ++++++++++++++++++++
 tb/tb_kerygma_bus_arb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kerygma_bus_arb.sv
// kerygma_bus_arb
//   Two-master to one-slave arbiter for 32-bit split-transaction buses.
//   One master is granted per cycle and its request is forwarded to the slave
//   with zero latency; ack means the slave accepted it. The master ID of each
//   accepted read is queued in order, and every later slave response is routed
//   back to the master at the head of that queue.
//
// Parameters
//   OUTSTANDING_DEPTH  max accepted-but-unanswered reads (power of 2, >= 2)
//
// Ports
//   clk_i, arst_n_i                       clock, async active-low reset
//   mK_req_i/we_i/addr_bi/be_bi/wdata_bi  master K request (K = 0, 1)
//   mK_ack_o                              master K request accepted this cycle
//   mK_resp_o, mK_rdata_bo                master K read response / data
//   s_req_o/we_o/addr_bo/be_bo/wdata_bo   forwarded request to the slave
//   s_ack_i, s_resp_i, s_rdata_bi         slave accept, response, read data
//   err_o                                 sticky: response with no read outstanding
//
// Configuration
//   KERYGMA_BUS_ARB_FIXED_PRIO_EN  defined: m0 wins every tie (no round-robin)
module kerygma_bus_arb #(
   parameter int unsigned OUTSTANDING_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_bi,
   input  logic [3:0]  m0_be_bi,
   input  logic [31:0] m0_wdata_bi,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_bo,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_bi,
   input  logic [3:0]  m1_be_bi,
   input  logic [31:0] m1_wdata_bi,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_bo,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_bo,
   output logic [3:0]  s_be_bo,
   output logic [31:0] s_wdata_bo,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_bi,
   output logic        err_o
);

   localparam int unsigned PW = $clog2(OUTSTANDING_DEPTH);

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_M0   = 2'd1,
      LOCK_M1   = 2'd2
   } lock_e;

   lock_e                        lock_q, lock_d;
   logic [OUTSTANDING_DEPTH-1:0] id_q, id_d;      // one master-ID bit per slot
   logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
   logic [PW:0]                  cnt_q, cnt_d;
   logic                         err_q, err_d;
`ifndef KERYGMA_BUS_ARB_FIXED_PRIO_EN
   logic                         rr_q, rr_d;
`endif

   logic full, empty, elig0, elig1;
   logic gnt_vld, gnt_id, hs, push, pop, head_id;

   assign full  = (cnt_q == (PW+1)'(OUTSTANDING_DEPTH));
   assign empty = (cnt_q == '0);

   // Full blocks reads only; the occupancy is the registered one, so a pop in
   // the same cycle does not free a slot until the next cycle.
   assign elig0 = m0_req_i & (m0_we_i | ~full);
   assign elig1 = m1_req_i & (m1_we_i | ~full);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (!arst_n_i) begin
         gnt_vld = 1'b0;
      end else if (lock_q == LOCK_M0) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (lock_q == LOCK_M1) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end else if (elig0 && elig1) begin
         gnt_vld = 1'b1;
`ifdef KERYGMA_BUS_ARB_FIXED_PRIO_EN
         gnt_id  = 1'b0;
`else
         gnt_id  = rr_q;
`endif
      end else if (elig0) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (elig1) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   always_comb begin
      s_req_o    = 1'b0;
      s_we_o     = 1'b0;
      s_addr_bo  = '0;
      s_be_bo    = '0;
      s_wdata_bo = '0;
      if (gnt_vld) begin
         s_req_o = 1'b1;
         if (gnt_id) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
         end else begin
            s_we_o     = m0_we_i;
            s_addr_bo  = m0_addr_bi;
            s_be_bo    = m0_be_bi;
            s_wdata_bo = m0_wdata_bi;
         end
      end
   end

   assign hs       = gnt_vld & s_ack_i;
   assign m0_ack_o = hs & ~gnt_id;
   assign m1_ack_o = hs & gnt_id;
   assign push     = hs & ~s_we_o;
   assign pop      = arst_n_i & s_resp_i & ~empty;
   assign head_id  = id_q[rd_ptr_q];

   assign m0_resp_o   = pop & ~head_id;
   assign m1_resp_o   = pop & head_id;
   assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
   assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
   assign err_o       = err_q;

   always_comb begin
      lock_d   = lock_q;
      id_d     = id_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q | (s_resp_i & empty);
`ifndef KERYGMA_BUS_ARB_FIXED_PRIO_EN
      rr_d     = hs ? ~gnt_id : rr_q;
`endif
      if (push) begin
         id_d[wr_ptr_q] = gnt_id;
         wr_ptr_d       = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end
      // A granted but stalled request pins the grant until the slave takes it.
      case (lock_q)
         LOCK_NONE: if (gnt_vld && !s_ack_i) lock_d = gnt_id ? LOCK_M1 : LOCK_M0;
         LOCK_M0,
         LOCK_M1:   if (hs) lock_d = LOCK_NONE;
         default:   lock_d = LOCK_NONE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         lock_q   <= LOCK_NONE;
         id_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
`ifndef KERYGMA_BUS_ARB_FIXED_PRIO_EN
         rr_q     <= 1'b0;
`endif
      end else begin
         lock_q   <= lock_d;
         id_q     <= id_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`ifndef KERYGMA_BUS_ARB_FIXED_PRIO_EN
         rr_q     <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_kerygma_bus_arb.sv
// Testbench for kerygma_bus_arb: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_kerygma_bus_arb;

   localparam int DEPTH = 4;
`ifdef KERYGMA_BUS_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arst_n_i = 1'b0;
   logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
   logic [31:0] m0_addr_bi = '0, m0_wdata_bi = '0;
   logic [3:0]  m0_be_bi = '0;
   logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
   logic [31:0] m1_addr_bi = '0, m1_wdata_bi = '0;
   logic [3:0]  m1_be_bi = '0;
   logic        s_ack_i = 1'b0, s_resp_i = 1'b0;
   logic [31:0] s_rdata_bi = '0;

   logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
   logic [31:0] m0_rdata_bo, m1_rdata_bo;
   logic        s_req_o, s_we_o, err_o;
   logic [31:0] s_addr_bo, s_wdata_bo;
   logic [3:0]  s_be_bo;

   kerygma_bus_arb #(.OUTSTANDING_DEPTH(DEPTH)) dut (
      .clk_i(clk), .arst_n_i(arst_n_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi),
      .m0_be_bi(m0_be_bi), .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o),
      .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi),
      .m1_be_bi(m1_be_bi), .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o),
      .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
      .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i),
      .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi), .err_o(err_o)
   );

   logic [138:0] all_out;
   assign all_out = {s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo,
                     m0_ack_o, m0_resp_o, m0_rdata_bo,
                     m1_ack_o, m1_resp_o, m1_rdata_bo, err_o};

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: lock owner (-1 = none), next tie winner, queue of read owners.
   int lock_m;
   int rr_m;
   int fifo_m[$];
   bit err_m;

   task automatic model_reset();
      lock_m = -1;
      rr_m   = 0;
      fifo_m.delete();
      err_m  = 1'b0;
   endtask

   function automatic int exp_grant();
      bit e0, e1;
      e0 = m0_req_i && (m0_we_i || fifo_m.size() < DEPTH);
      e1 = m1_req_i && (m1_we_i || fifo_m.size() < DEPTH);
      if (lock_m >= 0) return lock_m;
      if (e0 && e1)    return FIXED ? 0 : rr_m;
      if (e0)          return 0;
      if (e1)          return 1;
      return -1;
   endfunction

   task automatic model_step();
      int g;
      bit hs, we_g;
      g  = exp_grant();
      hs = (g >= 0) && s_ack_i;
      if (s_resp_i) begin
         if (fifo_m.size() > 0) void'(fifo_m.pop_front());
         else err_m = 1'b1;
      end
      if (hs) begin
         we_g = (g == 0) ? m0_we_i : m1_we_i;
         rr_m = 1 - g;
         if (!we_g) fifo_m.push_back(g);
      end
      if (lock_m < 0) begin
         if (g >= 0 && !s_ack_i) lock_m = g;
      end else if (hs) begin
         lock_m = -1;
      end
   endtask

   task automatic clear_inputs();
      m0_req_i = 0; m0_we_i = 0; m0_addr_bi = '0; m0_be_bi = '0; m0_wdata_bi = '0;
      m1_req_i = 0; m1_we_i = 0; m1_addr_bi = '0; m1_be_bi = '0; m1_wdata_bi = '0;
      s_ack_i = 0; s_resp_i = 0; s_rdata_bi = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      arst_n_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      arst_n_i = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      arst_n_i = 1'b0;
      m0_req_i = 1; m0_addr_bi = 32'hDEAD_BEEF; m1_req_i = 1; m1_we_i = 1;
      s_ack_i = 1; s_resp_i = 1; s_rdata_bi = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      n_total++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (all_out !== '0) $display("FAIL reset_outputs_edge: got %h expected 0", all_out);
      else n_pass++;
      do_reset();
      #1;
      n_total++;
      if ({s_req_o, err_o} !== 2'b00) $display("FAIL reset_release: got %b expected 00", {s_req_o, err_o});
      else n_pass++;
   endtask

   task automatic test_single_write();
      do_reset();
      @(negedge clk);
      m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h8000_0000; m0_be_bi = 4'hF;
      m0_wdata_bi = 32'h5A; s_ack_i = 1;
      #1;
      n_total++;
      if ({s_req_o, s_we_o, s_addr_bo, s_wdata_bo} !== {2'b11, 32'h8000_0000, 32'h5A})
         $display("FAIL write_fwd: got %b %b %h %h expected 1 1 80000000 0000005a",
                  s_req_o, s_we_o, s_addr_bo, s_wdata_bo);
      else n_pass++;
      n_total++;
      if ({m0_ack_o, m1_ack_o, m0_resp_o} !== 3'b100)
         $display("FAIL write_ack: got %b expected 100", {m0_ack_o, m1_ack_o, m0_resp_o});
      else n_pass++;
      @(negedge clk);
      m0_req_i = 0;
      #1;
      n_total++;
      if ({s_req_o, m0_ack_o, m0_resp_o} !== 3'b000)
         $display("FAIL write_idle: got %b expected 000", {s_req_o, m0_ack_o, m0_resp_o});
      else n_pass++;
      // A response now must find the queue empty: the write pushed nothing.
      @(negedge clk);
      s_resp_i = 1; s_rdata_bi = 32'h1234_5678;
      #1;
      n_total++;
      if ({m0_resp_o, m1_resp_o} !== 2'b00)
         $display("FAIL write_no_push_resp: got %b expected 00", {m0_resp_o, m1_resp_o});
      else n_pass++;
      @(negedge clk);
      s_resp_i = 0;
      #1;
      n_total++;
      if (err_o !== 1'b1) $display("FAIL write_no_push_err: got %b expected 1", err_o);
      else n_pass++;
   endtask

   task automatic test_rr_reads();
      logic [31:0] a[2];
      logic [31:0] prev_addr;
      int prev_g, g;
      do_reset();
      a[0] = $urandom; a[1] = $urandom;
      prev_g = -1; prev_addr = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         m0_req_i = 1; m0_we_i = 0; m0_addr_bi = a[0]; m0_be_bi = 4'hF;
         m1_req_i = 1; m1_we_i = 0; m1_addr_bi = a[1]; m1_be_bi = 4'hF;
         s_ack_i = 1; s_resp_i = (prev_g >= 0); s_rdata_bi = prev_addr;
         #1;
         g = FIXED ? 0 : c % 2;
         n_total++;
         if (s_addr_bo !== a[g]) $display("FAIL rr_grant_addr c%0d: got %h expected %h", c, s_addr_bo, a[g]);
         else n_pass++;
         n_total++;
         if ({m1_ack_o, m0_ack_o} !== ((g == 1) ? 2'b10 : 2'b01))
            $display("FAIL rr_ack c%0d: got %b expected m%0d", c, {m1_ack_o, m0_ack_o}, g);
         else n_pass++;
         if (prev_g >= 0) begin
            n_total++;
            if ({m0_resp_o, m0_rdata_bo, m1_resp_o, m1_rdata_bo} !==
                ((prev_g == 0) ? {1'b1, prev_addr, 33'b0} : {33'b0, 1'b1, prev_addr}))
               $display("FAIL rr_resp c%0d: got %b/%h %b/%h expected to m%0d data %h",
                        c, m0_resp_o, m0_rdata_bo, m1_resp_o, m1_rdata_bo, prev_g, prev_addr);
            else n_pass++;
         end
         prev_g = g; prev_addr = a[g];
         a[g] = $urandom;
      end
   endtask

   task automatic test_stall_lock();
      logic [31:0] a0, a1;
      do_reset();
      a0 = $urandom; a1 = $urandom;
      @(negedge clk);
      m1_req_i = 1; m1_we_i = 0; m1_addr_bi = a1; s_ack_i = 0;
      #1;
      n_total++;
      if ({s_req_o, s_addr_bo, m1_ack_o} !== {1'b1, a1, 1'b0})
         $display("FAIL stall_first: got %b %h %b expected 1 %h 0", s_req_o, s_addr_bo, m1_ack_o, a1);
      else n_pass++;
      for (int c = 1; c < 5; c++) begin
         @(negedge clk);
         m0_req_i = 1; m0_we_i = 0; m0_addr_bi = a0;
         #1;
         n_total++;
         if ({s_addr_bo, m0_ack_o, m1_ack_o} !== {a1, 2'b00})
            $display("FAIL stall_hold c%0d: got %h %b%b expected %h 00", c, s_addr_bo, m0_ack_o, m1_ack_o, a1);
         else n_pass++;
      end
      @(negedge clk);
      s_ack_i = 1;
      #1;
      n_total++;
      if ({s_addr_bo, m0_ack_o, m1_ack_o} !== {a1, 2'b01})
         $display("FAIL stall_release: got %h %b%b expected %h 01", s_addr_bo, m0_ack_o, m1_ack_o, a1);
      else n_pass++;
      @(negedge clk);
      m1_req_i = 0;
      #1;
      n_total++;
      if ({s_addr_bo, m0_ack_o, m1_ack_o} !== {a0, 2'b10})
         $display("FAIL stall_next_m0: got %h %b%b expected %h 10", s_addr_bo, m0_ack_o, m1_ack_o, a0);
      else n_pass++;
   endtask

   task automatic test_full();
      logic [31:0] a4, wa, rd;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         m0_req_i = 1; m0_we_i = 0; m0_addr_bi = $urandom; s_ack_i = 1;
         #1;
         n_total++;
         if (m0_ack_o !== 1'b1) $display("FAIL full_fill%0d: got %b expected 1", i, m0_ack_o);
         else n_pass++;
      end
      a4 = $urandom; wa = $urandom; rd = $urandom;
      @(negedge clk);
      m0_addr_bi = a4;
      m1_req_i = 1; m1_we_i = 1; m1_addr_bi = wa; m1_wdata_bi = $urandom;
      #1;
      n_total++;
      if ({m0_ack_o, m1_ack_o, s_we_o, s_addr_bo} !== {3'b011, wa})
         $display("FAIL full_block: got %b%b%b %h expected 011 %h", m0_ack_o, m1_ack_o, s_we_o, s_addr_bo, wa);
      else n_pass++;
      @(negedge clk);
      m1_req_i = 0; s_resp_i = 1; s_rdata_bi = rd;
      #1;
      n_total++;
      if ({m0_ack_o, s_req_o, m0_resp_o, m0_rdata_bo} !== {3'b001, rd})
         $display("FAIL full_pop_cycle: got %b%b%b %h expected 001 %h", m0_ack_o, s_req_o, m0_resp_o, m0_rdata_bo, rd);
      else n_pass++;
      @(negedge clk);
      s_resp_i = 0;
      #1;
      n_total++;
      if ({m0_ack_o, s_addr_bo} !== {1'b1, a4})
         $display("FAIL full_after_pop: got %b %h expected 1 %h", m0_ack_o, s_addr_bo, a4);
      else n_pass++;
   endtask

   task automatic test_err();
      do_reset();
      @(negedge clk);
      s_resp_i = 1; s_rdata_bi = $urandom;
      #1;
      n_total++;
      if ({m0_resp_o, m1_resp_o, m0_rdata_bo, m1_rdata_bo, err_o} !== '0)
         $display("FAIL err_stray_resp: got %b%b %h %h %b expected all 0",
                  m0_resp_o, m1_resp_o, m0_rdata_bo, m1_rdata_bo, err_o);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         s_resp_i = 0;
         #1;
         n_total++;
         if (err_o !== 1'b1) $display("FAIL err_sticky c%0d: got %b expected 1", c, err_o);
         else n_pass++;
      end
      arst_n_i = 1'b0;
      #1;
      n_total++;
      if (err_o !== 1'b0) $display("FAIL err_clear_on_reset: got %b expected 0", err_o);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_random(input int unsigned n);
      bit          pend[2];
      bit          twe[2];
      logic [31:0] taddr[2], twd[2];
      logic [3:0]  tbe[2];
      int          g, h;
      logic [69:0] exp_fwd;
      logic [1:0]  exp_ack;
      logic [65:0] exp_rsp;
      do_reset();
      for (int k = 0; k < 2; k++) pend[k] = 1'b0;
      for (int unsigned c = 0; c < n; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && $urandom_range(2) == 0) begin
               pend[k] = 1'b1; twe[k] = 1'($urandom_range(1));
               taddr[k] = $urandom; twd[k] = $urandom; tbe[k] = 4'($urandom);
            end
         end
         m0_req_i = pend[0]; m0_we_i = pend[0] & twe[0];
         m0_addr_bi = pend[0] ? taddr[0] : '0; m0_wdata_bi = pend[0] ? twd[0] : '0; m0_be_bi = pend[0] ? tbe[0] : '0;
         m1_req_i = pend[1]; m1_we_i = pend[1] & twe[1];
         m1_addr_bi = pend[1] ? taddr[1] : '0; m1_wdata_bi = pend[1] ? twd[1] : '0; m1_be_bi = pend[1] ? tbe[1] : '0;
         s_ack_i  = ($urandom_range(3) != 0);
         s_resp_i = (fifo_m.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(15) == 0);
         s_rdata_bi = $urandom;
         #1;
         g = exp_grant();
         exp_fwd = '0;
         if (g == 0)      exp_fwd = {1'b1, m0_we_i, m0_addr_bi, m0_be_bi, m0_wdata_bi};
         else if (g == 1) exp_fwd = {1'b1, m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi};
         exp_ack = {(g == 1) && s_ack_i, (g == 0) && s_ack_i};
         exp_rsp = '0;
         if (s_resp_i && fifo_m.size() > 0) begin
            h = fifo_m[0];
            exp_rsp = (h == 0) ? {1'b1, s_rdata_bi, 33'b0} : {33'b0, 1'b1, s_rdata_bi};
         end
         n_total++;
         if ({s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo} !== exp_fwd)
            $display("FAIL rand_fwd c%0d: got %h expected %h", c,
                     {s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo}, exp_fwd);
         else n_pass++;
         n_total++;
         if ({m1_ack_o, m0_ack_o} !== exp_ack)
            $display("FAIL rand_ack c%0d: got %b expected %b", c, {m1_ack_o, m0_ack_o}, exp_ack);
         else n_pass++;
         n_total++;
         if ({m0_resp_o, m0_rdata_bo, m1_resp_o, m1_rdata_bo} !== exp_rsp)
            $display("FAIL rand_resp c%0d: got %h expected %h", c,
                     {m0_resp_o, m0_rdata_bo, m1_resp_o, m1_rdata_bo}, exp_rsp);
         else n_pass++;
         n_total++;
         if (err_o !== err_m) $display("FAIL rand_err c%0d: got %b expected %b", c, err_o, err_m);
         else n_pass++;
         if (exp_ack[0]) pend[0] = 1'b0;
         if (exp_ack[1]) pend[1] = 1'b0;
         model_step();
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      @(negedge clk);
      m0_req_i = 1; m0_we_i = 0; m0_addr_bi = $urandom; s_ack_i = 1;
      #1;
      n_total++;
      if (m0_ack_o !== 1'b1) $display("FAIL mid_read_accept: got %b expected 1", m0_ack_o);
      else n_pass++;
      @(negedge clk);
      m0_addr_bi = $urandom; m1_req_i = 1; m1_addr_bi = $urandom; s_ack_i = 0;
      #2;
      arst_n_i = 1'b0;
      #1;
      n_total++;
      if (all_out !== '0) $display("FAIL mid_reset_outputs: got %h expected 0", all_out);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      arst_n_i = 1'b1;
      @(negedge clk);
      s_resp_i = 1; s_rdata_bi = $urandom;
      #1;
      n_total++;
      if ({m0_resp_o, m1_resp_o} !== 2'b00)
         $display("FAIL mid_discarded_resp: got %b expected 00", {m0_resp_o, m1_resp_o});
      else n_pass++;
      @(negedge clk);
      s_resp_i = 0;
      #1;
      n_total++;
      if (err_o !== 1'b1) $display("FAIL mid_err_set: got %b expected 1", err_o);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_single_write();
      test_rr_reads();
      test_stall_lock();
      test_full();
      test_err();
      test_random(400);
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
